// File: rtl/intf_mem_ctrl_pkg.sv
// Shared opcodes, controller states and memory-port constants for the SPI byte-command
// memory controller.
package intf_mem_ctrl_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_RELEASE = 8'hA5;
  localparam logic [7:0] OP_GRAB    = 8'h5A;

  localparam logic [1:0] MEM_LEN_WORD = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WDATA,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RDATA,
    ST_DROP
  } state_t;

endpackage

// File: rtl/intf_word_shifter.sv
// Word register shared by the rx and tx paths. Rx bytes enter at the top, so the first
// byte ends up in bits 7:0. A parallel load followed by shifts returns byte 0 first.
module intf_word_shifter #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              shift_in,
  input  logic [7:0]        byte_in,
  input  logic              load,
  input  logic [WORD_W-1:0] word_in,
  input  logic              shift_out,
  output logic [WORD_W-1:0] word,
  output logic [7:0]        byte_out
);

  logic [WORD_W-1:0] word_q;

  always_ff @(posedge clk) begin
    if (load)
      word_q <= word_in;
    else if (shift_in)
      word_q <= {byte_in, word_q[WORD_W-1:8]};
    else if (shift_out)
      word_q <= {8'h00, word_q[WORD_W-1:8]};
  end

  assign word     = word_q;
  assign byte_out = word_q[7:0];

endmodule

// File: rtl/intf_mem_ctrl.sv
// Byte-command memory controller. It parses opcode/address/data frames from the SPI slave
// and drives single-word accesses on the memory interface port.
// Define INTF_MEM_CTRL_BURST_EN to let a frame run on to consecutive addresses until
// frame_active drops.
module intf_mem_ctrl
  import intf_mem_ctrl_pkg::*;
#(
  parameter int ADDRESS_LENGTH = 12,
  parameter int DATA_LENGTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_active,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      core_select,
  output logic                      mem_en,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [ADDRESS_LENGTH-1:0] mem_address,
  output logic [DATA_LENGTH-1:0]    mem_data_in,
  output logic [1:0]                mem_data_length,
  input  logic [DATA_LENGTH-1:0]    mem_data_out,
  output logic                      busy
);

  state_t state, state_nxt;

  logic [7:0]                opcode_q;
  logic [7:0]                addr_hi_q;
  logic [ADDRESS_LENGTH-1:0] addr_q;
  logic [1:0]                cnt_q;
  logic                      core_sel_q;
  logic                      rx_take, tx_take, last_byte, addr_inc;
  logic                      is_write, is_read;
  logic [DATA_LENGTH-1:0]    word;
  logic [7:0]                tx_byte;

  assign rx_take   = rx_valid & frame_active;
  assign tx_take   = (state == ST_RDATA) & tx_ready;
  assign last_byte = (cnt_q == 2'd3);
  assign is_write  = (opcode_q == OP_WRITE);
  assign is_read   = (opcode_q == OP_READ);

`ifdef INTF_MEM_CTRL_BURST_EN
  assign addr_inc = (state == ST_WRITE) | (tx_take & last_byte);
`else
  assign addr_inc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Control registers: arbitration bit and the byte counter shared by WDATA and RDATA.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_sel_q <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      if (state == ST_CMD && frame_active) begin
        if (opcode_q == OP_RELEASE)
          core_sel_q <= 1'b1;
        else if (opcode_q == OP_GRAB)
          core_sel_q <= 1'b0;
      end
      if ((state == ST_WDATA && rx_take) || tx_take)
        cnt_q <= cnt_q + 2'd1;
      else if (state != ST_WDATA && state != ST_RDATA)
        cnt_q <= 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && rx_take)
      opcode_q <= rx_data;
    if (state == ST_ADDR_HI && rx_take)
      addr_hi_q <= rx_data;
    if (state == ST_ADDR_LO && rx_take)
      addr_q <= ADDRESS_LENGTH'({addr_hi_q, rx_data});
    else if (addr_inc)
      addr_q <= addr_q + ADDRESS_LENGTH'(1);
  end

  always_comb begin
    state_nxt = state;
    if (!frame_active) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (rx_valid) state_nxt = ST_CMD;
        ST_CMD:      state_nxt = ((is_write || is_read) && !core_sel_q) ? ST_ADDR_HI : ST_DROP;
        ST_ADDR_HI:  if (rx_valid) state_nxt = ST_ADDR_LO;
        ST_ADDR_LO:  if (rx_valid) state_nxt = is_write ? ST_WDATA : ST_RD_ISSUE;
        ST_WDATA:    if (rx_valid && last_byte) state_nxt = ST_WRITE;
`ifdef INTF_MEM_CTRL_BURST_EN
        ST_WRITE:    state_nxt = ST_WDATA;
        ST_RDATA:    if (tx_ready && last_byte) state_nxt = ST_RD_ISSUE;
`else
        ST_WRITE:    state_nxt = ST_DROP;
        ST_RDATA:    if (tx_ready && last_byte) state_nxt = ST_DROP;
`endif
        ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
        ST_RD_WAIT:  state_nxt = ST_RDATA;
        ST_DROP:     state_nxt = ST_DROP;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // The read strobe spans RD_ISSUE and RD_WAIT; the word is latched at the end of RD_WAIT.
  always_comb begin
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    tx_valid    = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr_en = 1'b1;
      end
      ST_RD_ISSUE, ST_RD_WAIT: begin
        mem_en    = 1'b1;
        mem_rd_en = 1'b1;
      end
      ST_RDATA: tx_valid = 1'b1;
      default: ;
    endcase
    tx_data     = tx_valid ? tx_byte : 8'h00;
    mem_address = busy ? addr_q : '0;
    mem_data_in = busy ? word : '0;
  end

  assign core_select     = core_sel_q;
  assign mem_data_length = MEM_LEN_WORD;

  intf_word_shifter #(
    .WORD_W(DATA_LENGTH)
  ) u_shifter (
    .clk      (clk),
    .shift_in (state == ST_WDATA && rx_take),
    .byte_in  (rx_data),
    .load     (state == ST_RD_WAIT),
    .word_in  (mem_data_out),
    .shift_out(tx_take),
    .word     (word),
    .byte_out (tx_byte)
  );

endmodule

// File: tb/tb_intf_mem_ctrl.sv
// Testbench for intf_mem_ctrl: frame table, hand-written timing sequences and random
// frames checked against a word-level memory and arbitration model.
module tb_intf_mem_ctrl;
  import intf_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, frame_active, rx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic        tx_valid, core_select, mem_en, mem_wr_en, mem_rd_en, busy;
  logic [11:0] mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  logic [1:0]  mem_data_length;

  always #5 clk = ~clk;

  intf_mem_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_active   (frame_active),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .core_select    (core_select),
    .mem_en         (mem_en),
    .mem_wr_en      (mem_wr_en),
    .mem_rd_en      (mem_rd_en),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_data_length(mem_data_length),
    .mem_data_out   (mem_data_out),
    .busy           (busy)
  );

  // Memory wrapper stand-in plus strobe monitor.
  bit [31:0]   mem_arr [4096];
  bit [31:0]   ref_mem [4096];
  int          wr_cnt, rd_cnt, tx_cnt;
  logic [11:0] wr_addr_log [256];
  logic [31:0] wr_data_log [256];

  assign mem_data_out = (mem_en && mem_rd_en) ? mem_arr[mem_address] : 32'h0;

  always @(posedge clk) begin
    if (mem_en && mem_wr_en) begin
      mem_arr[mem_address]     <= mem_data_in;
      wr_addr_log[wr_cnt[7:0]] <= mem_address;
      wr_data_log[wr_cnt[7:0]] <= mem_data_in;
      wr_cnt                   <= wr_cnt + 1;
    end
    if (mem_en && mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (tx_valid) tx_cnt <= tx_cnt + 1;
  end

  int vectors, miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic collect_word(output logic [31:0] w, output bit ok);
    int t;
    ok = 1'b1;
    w  = 32'h0;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!tx_valid && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (!tx_valid) begin
        ok = 1'b0;
        return;
      end
      w[8*k +: 8] = tx_data;
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [11:0] addr;
    logic [31:0] data;
    int          exp_wr;
    bit          exp_tx;
    logic [31:0] exp_word;
    bit          exp_cs;
  } frame_t;

  task automatic run_frame(input frame_t f, input string name);
    int          wr0, rd0, tx0;
    logic [31:0] w;
    bit          ok;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    tx0 = tx_cnt;
    @(negedge clk);
    frame_active = 1'b1;
    send_byte(f.op);
    if (f.op == OP_WRITE || f.op == OP_READ) begin
      send_byte({4'h0, f.addr[11:8]});
      send_byte(f.addr[7:0]);
    end
    if (f.op == OP_WRITE) begin
      for (int k = 0; k < 4; k++) send_byte(f.data[8*k +: 8]);
      if (f.exp_wr != 0) begin
        check({name, " wr strobe"}, {30'd0, mem_en, mem_wr_en}, 32'd3);
        check({name, " wr addr"}, {20'd0, mem_address}, {20'd0, f.addr});
        check({name, " wr data"}, mem_data_in, f.data);
        @(negedge clk);
        check({name, " wr one cycle"}, {31'd0, mem_wr_en}, 32'd0);
      end
    end
    if (f.exp_tx) begin
      collect_word(w, ok);
      check({name, " tx complete"}, {31'd0, ok}, 32'd1);
      check({name, " tx word"}, w, f.exp_word);
      check({name, " tx_valid after byte 3"}, {31'd0, tx_valid}, 32'd0);
    end else begin
      repeat (8) @(negedge clk);
    end
    frame_active = 1'b0;
    repeat (2) @(negedge clk);
    check({name, " busy idle"}, {31'd0, busy}, 32'd0);
    check({name, " core_select"}, {31'd0, core_select}, {31'd0, f.exp_cs});
    check({name, " write count"}, wr_cnt - wr0, f.exp_wr);
    if (!f.exp_tx) begin
      check({name, " no tx"}, tx_cnt - tx0, 32'd0);
      check({name, " no read"}, rd_cnt - rd0, 32'd0);
    end
`ifndef INTF_MEM_CTRL_BURST_EN
    else check({name, " read cycles"}, rd_cnt - rd0, 32'd2);
`endif
  endtask

  frame_t tbl [10];

  initial begin
    int          wr0, t;
    logic [7:0]  idx;
    frame_t      f;
    bit          cs_m;
    int          r;

    tbl[0] = '{OP_WRITE,   12'h010, 32'hDEADBEEF, 1, 1'b0, 32'h0,        1'b0};
    tbl[1] = '{OP_READ,    12'h010, 32'h0,        0, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{8'h77,      12'h000, 32'h0,        0, 1'b0, 32'h0,        1'b0};
    tbl[3] = '{OP_RELEASE, 12'h000, 32'h0,        0, 1'b0, 32'h0,        1'b1};
    tbl[4] = '{OP_WRITE,   12'h020, 32'h01020304, 0, 1'b0, 32'h0,        1'b1};
    tbl[5] = '{8'h77,      12'h000, 32'h0,        0, 1'b0, 32'h0,        1'b1};
    tbl[6] = '{OP_READ,    12'h010, 32'h0,        0, 1'b0, 32'h0,        1'b1};
    tbl[7] = '{OP_GRAB,    12'h000, 32'h0,        0, 1'b0, 32'h0,        1'b0};
    tbl[8] = '{OP_WRITE,   12'hFFF, 32'h12345678, 1, 1'b0, 32'h0,        1'b0};
    tbl[9] = '{OP_READ,    12'hFFF, 32'h0,        0, 1'b1, 32'h12345678, 1'b0};

    rst_n        = 1'b0;
    frame_active = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    tx_ready     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset core_select", {31'd0, core_select}, 32'd0);
    check("reset strobes", {28'd0, mem_en, mem_wr_en, mem_rd_en, tx_valid}, 32'd0);
    check("reset mem_address", {20'd0, mem_address}, 32'd0);
    check("reset mem_data_in", mem_data_in, 32'd0);
    check("reset mem_data_length", {30'd0, mem_data_length}, 32'd3);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_frame(tbl[i], $sformatf("table[%0d]", i));

    // Read latency and tx back-pressure on byte 1.
    @(negedge clk);
    frame_active = 1'b1;
    send_byte(OP_READ);
    send_byte(8'h00);
    send_byte(8'h10);
    check("rd cycle 1", {30'd0, mem_en, mem_rd_en}, 32'd3);
    @(negedge clk);
    check("rd cycle 2", {29'd0, mem_en, mem_rd_en, tx_valid}, 32'b110);
    @(negedge clk);
    check("rd cycle 3", {30'd0, mem_rd_en, tx_valid}, 32'b01);
    check("tx byte 0", {24'd0, tx_data}, 32'hEF);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      check("tx stall holds byte 1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hBE});
      if (s < 3) @(negedge clk);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    check("tx byte 2", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hAD});
    @(negedge clk);
    check("tx byte 3", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hDE});
    @(negedge clk);
    tx_ready = 1'b0;
    check("tx_valid drops", {31'd0, tx_valid}, 32'd0);
    frame_active = 1'b0;
    repeat (2) @(negedge clk);

    // Partial write aborted by frame end, then a clean write.
    wr0 = wr_cnt;
    @(negedge clk);
    frame_active = 1'b1;
    send_byte(OP_WRITE);
    send_byte(8'h00);
    send_byte(8'h30);
    send_byte(8'h11);
    send_byte(8'h22);
    frame_active = 1'b0;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("abort no write", wr_cnt - wr0, 32'd0);
    f = '{OP_WRITE, 12'h030, 32'h55667788, 1, 1'b0, 32'h0, 1'b0};
    run_frame(f, "after abort");

    // rx strobes outside a frame are ignored.
    send_byte(OP_WRITE);
    check("rx without frame", {31'd0, busy}, 32'd0);

`ifdef INTF_MEM_CTRL_BURST_EN
    wr0 = wr_cnt;
    @(negedge clk);
    frame_active = 1'b1;
    send_byte(OP_WRITE);
    send_byte(8'h0F);
    send_byte(8'hFF);
    for (int k = 0; k < 4; k++) send_byte(8'hA0 + 8'(k));
    for (int k = 0; k < 4; k++) send_byte(8'hB0 + 8'(k));
    frame_active = 1'b0;
    repeat (2) @(negedge clk);
    check("burst write count", wr_cnt - wr0, 32'd2);
    idx = wr0[7:0];
    check("burst addr 0", {20'd0, wr_addr_log[idx]}, 32'hFFF);
    check("burst data 0", wr_data_log[idx], 32'hA3A2A1A0);
    idx = idx + 8'd1;
    check("burst addr wrap", {20'd0, wr_addr_log[idx]}, 32'h000);
    check("burst data 1", wr_data_log[idx], 32'hB3B2B1B0);
`endif

    // Random frames against the word-level model.
    cs_m = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r          = $urandom_range(0, 9);
      f.addr     = 12'h100 + 12'($urandom_range(0, 7));
      f.data     = $urandom;
      f.exp_wr   = 0;
      f.exp_tx   = 1'b0;
      f.exp_word = 32'h0;
      if (r <= 3) begin
        f.op = OP_WRITE;
        if (!cs_m) begin
          f.exp_wr        = 1;
          ref_mem[f.addr] = f.data;
        end
      end else if (r <= 6) begin
        f.op = OP_READ;
        if (!cs_m) begin
          f.exp_tx   = 1'b1;
          f.exp_word = ref_mem[f.addr];
        end
      end else if (r == 7) begin
        f.op = OP_RELEASE;
        cs_m = 1'b1;
      end else if (r == 8) begin
        f.op = OP_GRAB;
        cs_m = 1'b0;
      end else begin
        f.op = 8'h10 + 8'($urandom_range(0, 63));
      end
      f.exp_cs = cs_m;
      run_frame(f, $sformatf("random[%0d] op %02h", i, f.op));
    end
    if (cs_m) begin
      f = '{OP_GRAB, 12'h000, 32'h0, 0, 1'b0, 32'h0, 1'b0};
      run_frame(f, "final grab");
    end

    // Reset in the middle of RDATA.
    @(negedge clk);
    frame_active = 1'b1;
    send_byte(OP_READ);
    send_byte(8'h00);
    send_byte(8'h10);
    t = 0;
    while (!tx_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("reset test reached RDATA", {31'd0, tx_valid}, 32'd1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid-read reset tx_valid", {31'd0, tx_valid}, 32'd0);
    check("mid-read reset core_select", {31'd0, core_select}, 32'd0);
    check("mid-read reset busy", {31'd0, busy}, 32'd0);
    check("mid-read reset strobes", {29'd0, mem_en, mem_wr_en, mem_rd_en}, 32'd0);
    rst_n        = 1'b1;
    frame_active = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench still running at %0t, required completion earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/intf_mem_ctrl.md
# intf_mem_ctrl

Byte-command memory controller between the SPI slave deserialiser and the data-memory wrapper's interface port. It parses opcode/address/data byte frames, issues single-word writes and reads on the `from_intf_mem_ctrl_*` port, streams read data back as bytes, and owns the `core_select` arbitration bit. At reset the interface owns the memory, so external loading completes before the core is released.

## Interface
- `ADDRESS_LENGTH`, 12: word-address width, matches the memory wrapper.
- `DATA_LENGTH`, 32: word width, fixed at 32 (four bytes per word).
- `clk` in 1: single clock, shared with the memory wrapper.
- `rst_n` in 1: synchronous reset, active-low.
- `frame_active` in 1: high while SPI chip-select is asserted.
- `rx_valid` in 1: one-cycle strobe, `rx_data` holds a received byte.
- `rx_data` in 8: received byte.
- `tx_data` out 8: byte to shift out.
- `tx_valid` out 1: `tx_data` is valid and held until `tx_ready`.
- `tx_ready` in 1: the deserialiser has taken `tx_data`.
- `core_select` out 1: 1 gives memory to the core, 0 gives it to this block.
- `mem_en`, `mem_wr_en`, `mem_rd_en` out 1 each: drive `from_intf_mem_ctrl_mem_*`.
- `mem_address` out ADDRESS_LENGTH: word address.
- `mem_data_in` out 32: write data.
- `mem_data_length` out 2: constant 2'b11, full-word write.
- `mem_data_out` in 32: `to_intf_mem_ctrl_mem_data_out`.
- `busy` out 1: high in any state other than IDLE.

## Operation
Frame layout: opcode byte, then ADDR_HI and ADDR_LO (big-endian, low ADDRESS_LENGTH bits used), then data. Write and read data are little-endian: the first byte is bits 7:0.

Opcodes:
- 0x02 WRITE: four data bytes follow.
- 0x03 READ: the block returns four bytes; rx bytes received during a read are dummies and are ignored.
- 0xA5 RELEASE: `core_select` is set to 1.
- 0x5A GRAB: `core_select` is set to 0.
- Any other opcode, or WRITE/READ while `core_select`=1, sends the block to DROP.

States and transitions:
- IDLE: the first `rx_valid` with `frame_active` high moves to CMD.
- CMD: decode the opcode.
- ADDR_HI, then ADDR_LO.
- WDATA: byte counter counts 0→3, then WRITE.
- WRITE: issue the write.
- RD_ISSUE, then RD_WAIT: issue the read and capture.
- RDATA: send bytes 0→3.
- DROP: ignore all bytes until the frame ends.

After one word (no burst), the block goes to DROP. RELEASE and GRAB go to DROP after updating `core_select`.

Outputs in reset and IDLE: `mem_en`, `mem_wr_en`, `mem_rd_en`, `tx_valid`, `busy` and `core_select` are 0. `mem_address` and `mem_data_in` are 0. `mem_data_length` is 2'b11.

## Timing
- The 4th write byte is sampled in cycle N. In cycle N+1, `mem_en` and `mem_wr_en` are high for exactly one cycle, with address and data stable.
- ADDR_LO of a READ is sampled in cycle N. `mem_en` and `mem_rd_en` are high in cycles N+1 and N+2. The read word is captured at the end of N+2, because the wrapper's output is only valid while `rd_en` is held. `tx_valid` rises in N+3 carrying byte 0.
- Each tx byte is held until `tx_valid`&`tx_ready`, then the next byte follows on the next cycle. `tx_valid` drops after byte 3 is accepted.
- `frame_active` low in any state returns the block to IDLE on the next cycle:
  - a partial write is discarded, with no strobe;
  - `tx_valid` drops;
  - `core_select` is kept.
- `rx_valid` while `frame_active` is low is ignored.
- `rst_n` low mid-frame returns the block to IDLE with reset values on the next edge. This includes `core_select`=0.

## Configuration
- `INTF_MEM_CTRL_BURST_EN` defined:
  - after WRITE, go back to WDATA with address+1;
  - after RDATA completes, go to RD_ISSUE with address+1;
  - the address wraps modulo 2^ADDRESS_LENGTH;
  - the burst ends only when `frame_active` drops.
- Undefined: one word per frame, then DROP.

## Structure
- Package `intf_mem_ctrl_pkg`:
  - opcode localparams OP_WRITE, OP_READ, OP_RELEASE, OP_GRAB;
  - the state enum;
  - `MEM_LEN_WORD` = 2'b11.
- Sub-module `intf_word_shifter`: a 32-bit register that does byte-wise assembly for rx (shift in at the top, 4 bytes) and parallel load plus byte-wise shift-out for tx (byte 0 first).

## Test plan
- WRITE frame 02 00 10 EF BE AD DE → one write strobe, `mem_address`=0x010, `mem_data_in`=0xDEADBEEF.
- READ 03 00 10 with the memory holding 0xDEADBEEF → `rd_en` high 2 cycles, tx bytes EF, BE, AD, DE; `tx_ready` stalled 3 cycles on byte 1 holds BE.
- `frame_active` dropped after 2 of the 4 write bytes → no `wr_en`, `busy`=0 the next cycle; a following valid write succeeds.
- Opcode 0x77, or 0x02 after 0xA5 RELEASE → no memory strobes, `core_select`=1 kept; 0x5A → `core_select`=0.
- With `INTF_MEM_CTRL_BURST_EN`: write 8 bytes at address 0xFFF → writes land at 0xFFF and then 0x000.
- `rst_n` low in the middle of RDATA → `tx_valid`=0, `core_select`=0, state IDLE.
